// File: rtl/inj_pulse_monitor.sv
// Injector line read-back monitor: synchronizes inj_in, measures on-time and period,
// hands results over valid/ready, flags stuck-on and missing pulses. Macro: INJ_MON_PHASE_STAMP_EN.
module inj_pulse_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 32,
  parameter int MIN_WIDTH   = 4,
  parameter int MAX_ON      = 2000000,
  parameter int MISS_LIMIT  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             inj_in,
  input  logic             trigger,
  input  logic [15:0]      eng_phase,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic [CNT_W-1:0] meas_on_cycles,
  output logic [CNT_W-1:0] meas_period_cycles,
  output logic [15:0]      meas_phase,
  input  logic             fault_clr,
  output logic             fault_stuck,
  output logic             fault_missing,
  output logic             glitch,
  output logic             overrun
);

  localparam int MISS_W = $clog2(MISS_LIMIT + 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  MIN_C    = CNT_W'(MIN_WIDTH);
  localparam logic [CNT_W-1:0]  MAX_C    = CNT_W'(MAX_ON);
  localparam logic [MISS_W-1:0] MISS_C   = MISS_W'(MISS_LIMIT);
  localparam logic [MISS_W-1:0] MISS_ONE = MISS_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_QUAL, S_ON, S_STUCK} state_t;

  state_t                   state_q, state_d;
  logic [SYNC_STAGES-1:0]   sync_q, sync_d;
  logic [CNT_W-1:0]         on_cnt_q, on_cnt_d;
  logic [CNT_W-1:0]         period_cnt_q, period_cnt_d;
  logic [CNT_W-1:0]         period_lat_q, period_lat_d;
  logic                     first_seen_q, first_seen_d;
  logic [MISS_W-1:0]        miss_cnt_q, miss_cnt_d;
  logic                     meas_valid_q, meas_valid_d;
  logic [CNT_W-1:0]         meas_on_q, meas_on_d;
  logic [CNT_W-1:0]         meas_period_q, meas_period_d;
  logic                     fault_stuck_q, fault_stuck_d;
  logic                     fault_missing_q, fault_missing_d;
  logic                     glitch_q, glitch_d;
  logic                     overrun_q, overrun_d;

  logic inj_s, phase0;
  logic accept, publish, set_glitch, set_stuck, set_missing;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], inj_in};
  assign inj_s  = sync_q[SYNC_STAGES-1];
  assign phase0 = trigger && (eng_phase == 16'd0);

  always_comb begin
    state_d      = state_q;
    on_cnt_d     = on_cnt_q;
    period_cnt_d = (&period_cnt_q) ? period_cnt_q : period_cnt_q + CNT_ONE;
    period_lat_d = period_lat_q;
    first_seen_d = first_seen_q;
    miss_cnt_d   = miss_cnt_q;
    accept       = 1'b0;
    publish      = 1'b0;
    set_glitch   = 1'b0;
    set_stuck    = 1'b0;
    set_missing  = 1'b0;
    case (state_q)
      S_IDLE: if (inj_s) begin
        on_cnt_d = CNT_ONE;
        if (MIN_C <= CNT_ONE) begin
          state_d = S_ON;
          accept  = 1'b1;
        end else begin
          state_d = S_QUAL;
        end
      end
      S_QUAL: if (inj_s) begin
        on_cnt_d = on_cnt_q + CNT_ONE;
        if (on_cnt_d == MIN_C) begin
          state_d = S_ON;
          accept  = 1'b1;
        end
      end else begin
        state_d    = S_IDLE;
        set_glitch = 1'b1;
      end
      S_ON: if (inj_s) begin
        on_cnt_d = on_cnt_q + CNT_ONE;
        if (on_cnt_d == MAX_C) begin
          state_d   = S_STUCK;
          set_stuck = 1'b1;
        end
      end else begin
        state_d = S_IDLE;
        publish = 1'b1;
      end
      S_STUCK: if (!inj_s) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (phase0) begin
      if (miss_cnt_q != MISS_C) miss_cnt_d = miss_cnt_q + MISS_ONE;
      set_missing = (miss_cnt_d == MISS_C);
    end
    // Period includes the accept cycle itself, so take the already-advanced count.
    if (accept) begin
      period_lat_d = first_seen_q ? period_cnt_d : '0;
      period_cnt_d = '0;
      first_seen_d = 1'b1;
      miss_cnt_d   = '0;
      set_missing  = 1'b0;
    end
    if (!en) begin
      state_d      = S_IDLE;
      on_cnt_d     = '0;
      period_cnt_d = '0;
      miss_cnt_d   = '0;
      first_seen_d = 1'b0;
      accept       = 1'b0;
      publish      = 1'b0;
      set_glitch   = 1'b0;
      set_stuck    = 1'b0;
      set_missing  = 1'b0;
    end
  end

  always_comb begin
    meas_valid_d  = meas_valid_q;
    meas_on_d     = meas_on_q;
    meas_period_d = meas_period_q;
    if (publish) begin
      meas_valid_d  = 1'b1;
      meas_on_d     = on_cnt_q;
      meas_period_d = period_lat_q;
    end else if (meas_valid_q && meas_ready) begin
      meas_valid_d = 1'b0;
    end
    // A set in the same cycle as fault_clr must survive.
    glitch_d        = set_glitch  | (glitch_q        & ~fault_clr);
    fault_stuck_d   = set_stuck   | (fault_stuck_q   & ~fault_clr);
    fault_missing_d = set_missing | (fault_missing_q & ~fault_clr);
    overrun_d       = (publish & meas_valid_q & ~meas_ready) | (overrun_q & ~fault_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      sync_q          <= '0;
      on_cnt_q        <= '0;
      period_cnt_q    <= '0;
      period_lat_q    <= '0;
      first_seen_q    <= 1'b0;
      miss_cnt_q      <= '0;
      meas_valid_q    <= 1'b0;
      meas_on_q       <= '0;
      meas_period_q   <= '0;
      fault_stuck_q   <= 1'b0;
      fault_missing_q <= 1'b0;
      glitch_q        <= 1'b0;
      overrun_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      sync_q          <= sync_d;
      on_cnt_q        <= on_cnt_d;
      period_cnt_q    <= period_cnt_d;
      period_lat_q    <= period_lat_d;
      first_seen_q    <= first_seen_d;
      miss_cnt_q      <= miss_cnt_d;
      meas_valid_q    <= meas_valid_d;
      meas_on_q       <= meas_on_d;
      meas_period_q   <= meas_period_d;
      fault_stuck_q   <= fault_stuck_d;
      fault_missing_q <= fault_missing_d;
      glitch_q        <= glitch_d;
      overrun_q       <= overrun_d;
    end
  end

`ifdef INJ_MON_PHASE_STAMP_EN
  logic [15:0] phase_lat_q, phase_lat_d, meas_phase_q, meas_phase_d;

  always_comb begin
    phase_lat_d  = accept  ? eng_phase   : phase_lat_q;
    meas_phase_d = publish ? phase_lat_q : meas_phase_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_lat_q  <= '0;
      meas_phase_q <= '0;
    end else begin
      phase_lat_q  <= phase_lat_d;
      meas_phase_q <= meas_phase_d;
    end
  end

  assign meas_phase = meas_phase_q;
`else
  assign meas_phase = 16'd0;
`endif

  assign meas_valid         = meas_valid_q;
  assign meas_on_cycles     = meas_on_q;
  assign meas_period_cycles = meas_period_q;
  assign fault_stuck        = fault_stuck_q;
  assign fault_missing      = fault_missing_q;
  assign glitch             = glitch_q;
  assign overrun            = overrun_q;

endmodule

// File: doc/inj_pulse_monitor.md
Name: inj_pulse_monitor

Overview:
Read-back monitor for the injector output line; it sits on the far end of the injector driver's pin, either as a loopback or as a feedback input.
- Synchronizes and glitch-filters the line.
- Measures on-time and edge-to-edge period in clk cycles.
- Hands each measurement to firmware over a valid/ready interface.
- Flags two faults: line stuck on, and pulses missing relative to engine phase-0 triggers.

Parameters:
SYNC_STAGES, 2, synchronizer flops on inj_in (minimum 2)
CNT_W, 32, width of the on-time and period counters
MIN_WIDTH, 4, consecutive high samples needed to accept a pulse (minimum 1)
MAX_ON, 2000000, on_cnt value that declares the line stuck on
MISS_LIMIT, 3, phase-0 triggers without an accepted pulse before fault_missing is raised

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
en  in  1  monitor enable
inj_in  in  1  asynchronous injector line
trigger  in  1  single-cycle engine-position strobe
eng_phase  in  16  engine phase; a trigger with eng_phase==0 is a phase-0 event
meas_valid  out  1  measurement available
meas_ready  in  1  consumer accepts the measurement
meas_on_cycles  out  CNT_W  high time, in cycles of inj_s
meas_period_cycles  out  CNT_W  cycles between accepted rising edges; 0 on the first pulse
meas_phase  out  16  eng_phase at acceptance (see Optional Feature)
fault_clr  in  1  clears sticky flags
fault_stuck  out  1  sticky: line stuck on
fault_missing  out  1  sticky: missing pulses
glitch  out  1  sticky: pulse shorter than MIN_WIDTH
overrun  out  1  sticky: unread measurement overwritten

Behaviour:
Reset and synchronization
- Reset is synchronous and active-high on clk; there is one clock.
- On rst: every output is 0, all counters are 0, FSM is in IDLE, first_seen=0.
- inj_s is inj_in delayed by SYNC_STAGES flops. The FSM acts only on inj_s.

FSM states
- IDLE: inj_s=1 -> QUAL with on_cnt=1.
- QUAL, inj_s=1: on_cnt+1.
  - When on_cnt reaches MIN_WIDTH (the cycle it becomes MIN_WIDTH): go to ON. This is the "accept".
  - On accept: period_lat = first_seen ? period_cnt : 0; period_cnt -> 0; first_seen -> 1; miss_cnt -> 0.
- QUAL, inj_s=0: -> IDLE, set glitch, no publish. on_cnt and period_cnt are not disturbed.
- ON, inj_s=1: on_cnt+1. When on_cnt reaches MAX_ON: -> STUCK and set fault_stuck.
- ON, inj_s=0: -> IDLE and publish (meas_on_cycles=on_cnt, meas_period_cycles=period_lat).
- STUCK: no publish. inj_s=0 -> IDLE.

Counters
- period_cnt increments every cycle while en=1 and saturates at all-ones.
- on_cnt is compared against MAX_ON before it can wrap.
- With MIN_WIDTH=1, the cycle that leaves IDLE is also the accept, so the FSM goes IDLE -> ON directly.

Publish and handshake
- Publish registers the data and sets meas_valid on the next clk edge. Total latency from the inj_in falling edge to meas_valid is SYNC_STAGES+1 cycles.
- meas_valid and the data are held until a cycle with meas_valid&&meas_ready; meas_valid then clears.
- Publish while meas_valid=1 and meas_ready=0: data is overwritten and overrun is set.
- Publish in the same cycle as an accepting handshake: new data, meas_valid stays 1, no overrun.

Missing-pulse detection
- miss_cnt counts trigger&&eng_phase==0 events while en=1 and saturates at MISS_LIMIT.
- Reaching MISS_LIMIT sets fault_missing.
- Accept and a trigger in the same cycle: the accept wins (miss_cnt=0).

Enable
- en=0: FSM forced to IDLE, on_cnt, period_cnt and miss_cnt cleared, first_seen=0, no publish.
- A pending meas_valid and the sticky flags are kept.
- Deasserting en mid-pulse discards that pulse.

Sticky flags
- fault_clr clears all four sticky flags.
- A set condition in the same cycle as fault_clr wins.
- rst mid-pulse discards the pulse.

Optional Feature:
INJ_MON_PHASE_STAMP_EN
- Defined: eng_phase is latched on the accept cycle and presented on meas_phase together with each publish, under the same hold/overwrite rules as the other measurement data.
- Undefined: meas_phase is tied to 0 and there is no latch.

Test Plan:
All scenarios use SYNC_STAGES=2, MIN_WIDTH=4, MAX_ON=1000, MISS_LIMIT=3, meas_ready=1 unless noted.
- Two clean pulses: inj_in high for 100 cycles, low for 400, high for 100 -> pulse 1 gives meas_on_cycles=100, period=0; pulse 2 gives on=100, period=500. meas_valid rises 3 cycles after each falling edge and lasts 1 cycle.
- Glitch: 3-cycle high on inj_in -> glitch=1, no meas_valid, and the next real pulse's period is measured from the previous accepted edge. fault_clr -> glitch=0.
- Stuck on: inj_in held high for 2000 cycles -> fault_stuck=1 when on_cnt reaches 1000, no publish on release, and the FSM accepts the next pulse normally.
- Overrun: meas_ready=0, two pulses -> overrun=1 and the data equals the second pulse. Then meas_ready=1 -> meas_valid clears after one cycle.
- Missing pulses: three phase-0 triggers with no pulse -> fault_missing=1. A trigger in the same cycle as an accept leaves the fault clear.
- Phase stamp (macro defined): eng_phase=0x1234 on the accept cycle -> meas_phase=0x1234. Macro undefined -> meas_phase=0.
